// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle.
// Optional HAZARD_PERF_EN adds the stall/flush performance counter outputs.
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic       ex_RFWe;
    logic [1:0] ex_RFWsrc;
    logic [4:0] ex_rfwaddr;
    logic       ex_br_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_stop;
    logic       ifid_stop;
    logic       idex_stop;
    logic       exmem_stop;
    logic       ifid_flush;
    logic       idex_flush;
    logic       memwb_flush;
    logic       mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_RFWe, ex_RFWsrc, ex_rfwaddr, ex_br_taken,
        output mem_req, mem_ready,
        input  pc_stop, ifid_stop, idex_stop, exmem_stop,
        input  ifid_flush, idex_flush, memwb_flush, mem_timeout
`ifdef HAZARD_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_RFWe, ex_RFWsrc, ex_rfwaddr, ex_br_taken,
        input  mem_req, mem_ready,
        output pc_stop, ifid_stop, idex_stop, exmem_stop,
        output ifid_flush, idex_flush, memwb_flush, mem_timeout
`ifdef HAZARD_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stop/flush generator: load-use, taken branch and data-memory wait with timeout.
// Optional HAZARD_PERF_EN adds saturating stall and flush cycle counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [1:0]  RFWSRC_MEM  = 2'b01
) (
    input logic        clk,
    input logic        rst,
    hazard_ctrl_if.slave hif
);
    localparam int unsigned     CntW    = $clog2(MEM_TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StMwait = 2'b01
    } state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;
    logic            lduse;
    logic            memstall;
    logic            pc_stop, ifid_stop, idex_stop, exmem_stop;
    logic            ifid_flush, idex_flush, memwb_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        lduse = hif.ex_RFWe && (hif.ex_RFWsrc == RFWSRC_MEM) && (hif.ex_rfwaddr != 5'd0) &&
                ((hif.id_rs1_used && (hif.id_rs1 == hif.ex_rfwaddr)) ||
                 (hif.id_rs2_used && (hif.id_rs2 == hif.ex_rfwaddr)));
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        memstall   = 1'b0;
        unique case (state_q)
            StRun: begin
                memstall = hif.mem_req && !hif.mem_ready;
                if (memstall) begin
                    state_d    = StMwait;
                    wait_cnt_d = '0;
                end
            end
            StMwait: begin
                memstall = !hif.mem_ready && (wait_cnt_q != CntLast);
                if (hif.mem_ready) begin
                    state_d = StRun;
                end else if (wait_cnt_q == CntLast) begin
                    // Forced release: let the pipeline move on and flag it stickily.
                    state_d   = StRun;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pc_stop     = 1'b0;
        ifid_stop   = 1'b0;
        idex_stop   = 1'b0;
        exmem_stop  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (!rst) begin
            if (memstall) begin
                pc_stop     = 1'b1;
                ifid_stop   = 1'b1;
                idex_stop   = 1'b1;
                exmem_stop  = 1'b1;
                memwb_flush = 1'b1;
            end else if (hif.ex_br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lduse) begin
                pc_stop    = 1'b1;
                ifid_stop  = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    assign hif.pc_stop     = pc_stop;
    assign hif.ifid_stop   = ifid_stop;
    assign hif.idex_stop   = idex_stop;
    assign hif.exmem_stop  = exmem_stop;
    assign hif.ifid_flush  = ifid_flush;
    assign hif.idex_flush  = idex_flush;
    assign hif.memwb_flush = memwb_flush;
    assign hif.mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stop && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((ifid_flush || idex_flush) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hif.stall_cnt = stall_cnt_q;
    assign hif.flush_cnt = flush_cnt_q;
`endif
endmodule
